// File: rtl/bombe_sweep_ctrl_pkg.sv
// Shared types and constants for the bombe position sweep controller.
package bombe_pkg;

    localparam int ALPHABET      = 26;
    localparam int POS_W         = 5;
    localparam int NUM_POSITIONS = 17576;
    localparam int HIT_W         = 4 * POS_W;
    localparam int POS_CNT_W     = 15;
    localparam int HIT_CNT_W     = 16;

    typedef logic [POS_W-1:0] pos_t;

    // One logged stop: rotor triple plus the plugboard mapping reported by the core.
    typedef struct packed {
        pos_t pos_2;
        pos_t pos_1;
        pos_t pos_0;
        pos_t mapping;
    } hit_rec_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_WAIT    = 4'd2,
        ST_HIT     = 4'd3,
        ST_ACK1    = 4'd4,
        ST_ACK2    = 4'd5,
        ST_SKIP    = 4'd6,
        ST_ADVANCE = 4'd7,
        ST_FIN     = 4'd8
    } sweep_state_t;

    // Single rotor step. Returns {wrapped, next}. Anything at or above the last
    // letter wraps to 0 and carries, so out-of-range seeds fall back into range.
    function automatic logic [POS_W:0] rotor_inc(input pos_t p);
        logic [POS_W:0] r;
        if (p >= pos_t'(ALPHABET - 1)) begin
            r = {1'b1, {POS_W{1'b0}}};
        end else begin
            r = {1'b0, p + 5'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bombe_sweep_ctrl_if.sv
// Hit-record drain stream from the sweep controller to the host.
interface bombe_sweep_ctrl_if;
    import bombe_pkg::*;

    logic     hit_valid;
    logic     hit_ready;
    hit_rec_t hit_data;

    modport master (output hit_valid, output hit_data, input hit_ready);
    modport slave  (input hit_valid, input hit_data, output hit_ready);

endinterface

// File: rtl/bombe_sweep_ctrl_hit_fifo.sv
// Show-ahead hit FIFO. Full/empty come only from the registered count, so a
// push while full is refused even if a pop happens in the same cycle.
module hit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the registered occupancy and compute next pointers/count.
    always_comb begin
        full      = (count_q == (AW+1)'(DEPTH));
        empty     = (count_q == {(AW+1){1'b0}});
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - (AW+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/bombe_sweep_ctrl.sv
// Sweep sequencer: walks the bombe core over all rotor start positions,
// logs stops into the hit FIFO and runs the stop/acknowledge handshake.
module bombe_sweep_ctrl
    import bombe_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [POS_W-1:0]     start_pos_0,
    input  logic [POS_W-1:0]     start_pos_1,
    input  logic [POS_W-1:0]     start_pos_2,
    input  logic                 bombe_valid,
    input  logic                 bombe_done,
    input  logic [POS_W-1:0]     bombe_mapping,
    output logic                 bombe_reset,
    output logic                 next_attempt_1,
    output logic                 next_attempt_2,
    output logic                 finish_compute,
    output logic [POS_W-1:0]     rotor_pos_0,
    output logic [POS_W-1:0]     rotor_pos_1,
    output logic [POS_W-1:0]     rotor_pos_2,
    output logic [HIT_CNT_W-1:0] hit_count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 sweep_done,
    bombe_sweep_ctrl_if.master   hit_if
);

    localparam int RC_W = $clog2(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    sweep_state_t         state_q, state_d;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
    pos_t                 pos0_q, pos0_d;
    pos_t                 pos1_q, pos1_d;
    pos_t                 pos2_q, pos2_d;
    logic [POS_CNT_W-1:0] pos_count_q, pos_count_d;
    logic [HIT_CNT_W-1:0] hit_count_q, hit_count_d;
    logic                 overflow_q, overflow_d;
    logic                 bombe_reset_q, bombe_reset_d;
    logic                 na1_q, na1_d;
    logic                 na2_q, na2_d;
    logic                 fc_q, fc_d;
    logic                 busy_q, busy_d;
    logic                 sweep_done_q, sweep_done_d;

    logic [POS_W:0]       inc0_s, inc1_s, inc2_s;
    logic                 push_s;
    hit_rec_t             rec_s;
    logic [HIT_W-1:0]     rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    // Next-state, odometer, counters and the Moore-decoded strobes for the next state.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        pos0_d      = pos0_q;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;
        pos_count_d = pos_count_q;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;
        push_s      = 1'b0;
        inc0_s      = rotor_inc(pos0_q);
        inc1_s      = rotor_inc(pos1_q);
        inc2_s      = rotor_inc(pos2_q);
        rec_s       = '{pos_2: pos2_q, pos_1: pos1_q, pos_0: pos0_q, mapping: bombe_mapping};

        // Abort takes precedence over all per-state work, including a pending push.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            rst_cnt_d = {RC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pos0_d      = start_pos_0;
                        pos1_d      = start_pos_1;
                        pos2_d      = start_pos_2;
                        pos_count_d = {POS_CNT_W{1'b0}};
                        hit_count_d = {HIT_CNT_W{1'b0}};
                        overflow_d  = 1'b0;
                        rst_cnt_d   = {RC_W{1'b0}};
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (rst_cnt_q == RC_LAST) begin
                        rst_cnt_d = {RC_W{1'b0}};
                        state_d   = ST_WAIT;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (bombe_valid) begin
                        state_d = ST_HIT;
                    end else if (bombe_done) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HIT: begin
                    if (!fifo_full_s) begin
                        push_s = 1'b1;
                        if (hit_count_q != {HIT_CNT_W{1'b1}}) begin
                            hit_count_d = hit_count_q + 16'd1;
                        end else begin
                            hit_count_d = hit_count_q;
                        end
                        state_d = ST_ACK1;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_SKIP;
                    end
                end
                ST_ACK1: state_d = ST_ACK2;
                ST_ACK2: state_d = ST_WAIT;
                ST_SKIP: state_d = ST_WAIT;
                ST_ADVANCE: begin
                    pos0_d = inc0_s[POS_W-1:0];
                    if (inc0_s[POS_W]) begin
                        pos1_d = inc1_s[POS_W-1:0];
                        if (inc1_s[POS_W]) begin
                            pos2_d = inc2_s[POS_W-1:0];
                        end else begin
                            pos2_d = pos2_q;
                        end
                    end else begin
                        pos1_d = pos1_q;
                    end
                    pos_count_d = pos_count_q + 15'd1;
                    if (pos_count_d == POS_CNT_W'(NUM_POSITIONS)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they align with state_q.
        bombe_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        na1_d         = (state_d == ST_ACK1);
        na2_d         = (state_d == ST_ACK2);
        fc_d          = (state_d == ST_SKIP);
        busy_d        = (state_d != ST_IDLE);
        sweep_done_d  = (state_d == ST_FIN);
    end

    // Sequencer state, odometer, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= {RC_W{1'b0}};
            pos0_q        <= {POS_W{1'b0}};
            pos1_q        <= {POS_W{1'b0}};
            pos2_q        <= {POS_W{1'b0}};
            pos_count_q   <= {POS_CNT_W{1'b0}};
            hit_count_q   <= {HIT_CNT_W{1'b0}};
            overflow_q    <= 1'b0;
            bombe_reset_q <= 1'b1;
            na1_q         <= 1'b0;
            na2_q         <= 1'b0;
            fc_q          <= 1'b0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            pos0_q        <= pos0_d;
            pos1_q        <= pos1_d;
            pos2_q        <= pos2_d;
            pos_count_q   <= pos_count_d;
            hit_count_q   <= hit_count_d;
            overflow_q    <= overflow_d;
            bombe_reset_q <= bombe_reset_d;
            na1_q         <= na1_d;
            na2_q         <= na2_d;
            fc_q          <= fc_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HIT_W)
    ) u_hit_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (rec_s),
        .pop   (hit_if.hit_ready),
        .rdata (rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign hit_if.hit_valid = !fifo_empty_s;
    assign hit_if.hit_data  = hit_rec_t'(rdata_s);

    assign bombe_reset    = bombe_reset_q;
    assign next_attempt_1 = na1_q;
    assign next_attempt_2 = na2_q;
    assign finish_compute = fc_q;
    assign rotor_pos_0    = pos0_q;
    assign rotor_pos_1    = pos1_q;
    assign rotor_pos_2    = pos2_q;
    assign hit_count      = hit_count_q;
    assign overflow       = overflow_q;
    assign busy           = busy_q;
    assign sweep_done     = sweep_done_q;

endmodule

// File: tb/tb_bombe_sweep_ctrl.sv
// Scoreboard bench for bombe_sweep_ctrl (FIFO_DEPTH=2, RST_CYCLES=2).
module tb_bombe_sweep_ctrl;
    import bombe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  sp0, sp1, sp2;
    logic        bombe_valid;
    logic        done_drv;
    logic        auto_done;
    logic [4:0]  mapping;
    logic        bombe_done_w;
    logic        bombe_reset, na1, na2, fc;
    logic [4:0]  rp0, rp1, rp2;
    logic [15:0] hit_count;
    logic        overflow, busy, sweep_done;

    int n_checks = 0;
    int n_fail   = 0;
    int sweep_pulses = 0;
    int load_entries = 0;
    int load_base    = 0;

    logic [19:0] hit_q[$];
    logic [30:0] sweep_q[$];

    bombe_sweep_ctrl_if hif();

    always #5 clk = ~clk;

    // Simple bombe stand-in: optionally reports exhaustion as soon as reset is released.
    assign bombe_done_w = done_drv | (auto_done & ~bombe_reset);

    bombe_sweep_ctrl #(
        .FIFO_DEPTH (2),
        .RST_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .start_pos_0    (sp0),
        .start_pos_1    (sp1),
        .start_pos_2    (sp2),
        .bombe_valid    (bombe_valid),
        .bombe_done     (bombe_done_w),
        .bombe_mapping  (mapping),
        .bombe_reset    (bombe_reset),
        .next_attempt_1 (na1),
        .next_attempt_2 (na2),
        .finish_compute (fc),
        .rotor_pos_0    (rp0),
        .rotor_pos_1    (rp1),
        .rotor_pos_2    (rp2),
        .hit_count      (hit_count),
        .overflow       (overflow),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .hit_if         (hif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pops the expected hit record whenever the host side accepts one.
    task automatic mon_hits();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (!reset && hif.hit_valid && hif.hit_ready) begin
                if (hit_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hit_unexpected: got 0x%0h, expected no record", hif.hit_data);
                end else begin
                    e = hit_q.pop_front();
                    chk("hit_data_pop", 32'(hif.hit_data), 32'(e));
                end
            end
        end
    endtask

    // Compares final rotor/hit count on every sweep_done pulse.
    task automatic mon_sweep();
        logic [30:0] e;
        forever begin
            @(negedge clk);
            if (!reset && sweep_done) begin
                sweep_pulses++;
                if (sweep_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sweep_done_unexpected: got pulse, expected none");
                end else begin
                    e = sweep_q.pop_front();
                    chk("sweep_final", 32'({rp2, rp1, rp0, hit_count}), 32'(e));
                end
            end
        end
    endtask

    // Counts entries into the reset-hold phase while busy.
    task automatic mon_loads();
        logic prev = 1'b0;
        logic now_s;
        forever begin
            @(negedge clk);
            now_s = busy && bombe_reset;
            if (now_s && !prev) load_entries++;
            prev = now_s;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        sp0 = 5'd0; sp1 = 5'd0; sp2 = 5'd0;
        bombe_valid = 1'b0; done_drv = 1'b0; auto_done = 1'b0; mapping = 5'd0;
        hif.hit_ready = 1'b0;
        fork
            mon_hits();
            mon_sweep();
            mon_loads();
        join_none

        // Reset state
        repeat (3) cyc();
        chk("rst_bombe_reset", 32'(bombe_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({na1, na2, fc, sweep_done}), 32'd0);
        chk("rst_rotor", 32'({rp2, rp1, rp0}), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_hit_valid", 32'(hif.hit_valid), 32'd0);
        reset = 1'b0;
        cyc();

        // Odometer carry through both upper rotors: 25/25/24 -> 0/0/25
        sp0 = 5'd25; sp1 = 5'd25; sp2 = 5'd24; start = 1'b1;
        cyc();  // LOAD 1
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_rotor_start", 32'({rp2, rp1, rp0}), 32'({5'd24, 5'd25, 5'd25}));
        chk("a_breset_load1", 32'(bombe_reset), 32'd1);
        sp0 = 5'd1; sp1 = 5'd1; sp2 = 5'd1;  // start held while busy: ignored
        cyc();  // LOAD 2
        start = 1'b0;
        chk("a_breset_load2", 32'(bombe_reset), 32'd1);
        chk("a_start_ignored", 32'({rp2, rp1, rp0}), 32'({5'd24, 5'd25, 5'd25}));
        cyc();  // WAIT
        chk("a_breset_wait", 32'(bombe_reset), 32'd0);
        done_drv = 1'b1;
        cyc();  // ADVANCE
        done_drv = 1'b0;
        chk("a_rotor_adv", 32'({rp2, rp1, rp0}), 32'({5'd24, 5'd25, 5'd25}));
        cyc();  // LOAD
        chk("a_rotor_wrap", 32'({rp2, rp1, rp0}), 32'({5'd25, 5'd0, 5'd0}));
        chk("a_breset_reload", 32'(bombe_reset), 32'd1);
        abort = 1'b1;
        cyc();  // IDLE
        abort = 1'b0;
        chk("a_abort_busy", 32'(busy), 32'd0);

        // Hit at 3/0/0 with mapping 7
        sp0 = 5'd3; sp1 = 5'd0; sp2 = 5'd0; start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        cyc();  // WAIT
        chk("h_breset_wait", 32'(bombe_reset), 32'd0);
        bombe_valid = 1'b1; mapping = 5'd7;
        hit_q.push_back({5'd0, 5'd0, 5'd3, 5'd7});
        cyc();  // HIT
        chk("h_hit_na1", 32'({na1, na2}), 32'd0);
        chk("h_hit_valid_early", 32'(hif.hit_valid), 32'd0);
        cyc();  // ACK1
        bombe_valid = 1'b0;
        chk("h_ack1", 32'({na1, na2}), 32'b10);
        chk("h_hit_valid", 32'(hif.hit_valid), 32'd1);
        chk("h_hit_data", 32'(hif.hit_data), 32'h67);
        cyc();  // ACK2
        chk("h_ack2", 32'({na1, na2}), 32'b01);
        cyc();  // WAIT
        chk("h_wait", 32'({na1, na2}), 32'b00);
        chk("h_count1", 32'(hit_count), 32'd1);

        // valid and done together: valid wins
        bombe_valid = 1'b1; done_drv = 1'b1; mapping = 5'd9;
        hit_q.push_back({5'd0, 5'd0, 5'd3, 5'd9});
        cyc();  // HIT
        done_drv = 1'b0;
        cyc();  // ACK1
        bombe_valid = 1'b0;
        chk("b_ack1", 32'(na1), 32'd1);
        chk("b_rotor_same", 32'({rp2, rp1, rp0}), 32'({5'd0, 5'd0, 5'd3}));
        cyc();
        cyc();  // WAIT
        chk("b_count2", 32'(hit_count), 32'd2);

        // Third hit with FIFO full -> dropped
        bombe_valid = 1'b1; mapping = 5'd13;
        cyc();  // HIT
        chk("o_ovf_before", 32'(overflow), 32'd0);
        cyc();  // SKIP
        bombe_valid = 1'b0;
        chk("o_fc", 32'(fc), 32'd1);
        chk("o_overflow", 32'(overflow), 32'd1);
        chk("o_na1_quiet", 32'(na1), 32'd0);
        chk("o_count2", 32'(hit_count), 32'd2);
        cyc();  // WAIT
        chk("o_fc_one_cycle", 32'(fc), 32'd0);
        chk("o_overflow_sticky", 32'(overflow), 32'd1);

        // Drain one, then abort during ACK1 of a new hit
        hif.hit_ready = 1'b1;
        cyc();
        hif.hit_ready = 1'b0;
        bombe_valid = 1'b1; mapping = 5'd11;
        hit_q.push_back({5'd0, 5'd0, 5'd3, 5'd11});
        cyc();  // HIT
        cyc();  // ACK1
        bombe_valid = 1'b0;
        chk("x_ack1", 32'(na1), 32'd1);
        abort = 1'b1;
        cyc();  // IDLE
        abort = 1'b0;
        chk("x_busy", 32'(busy), 32'd0);
        chk("x_breset", 32'(bombe_reset), 32'd1);
        chk("x_strobes", 32'({na1, na2, sweep_done}), 32'd0);
        chk("x_fifo_kept", 32'(hif.hit_valid), 32'd1);
        chk("x_count3", 32'(hit_count), 32'd3);
        hif.hit_ready = 1'b1;
        cyc();
        cyc();
        hif.hit_ready = 1'b0;
        cyc();
        chk("x_fifo_empty", 32'(hif.hit_valid), 32'd0);
        chk("x_hits_drained", 32'(hit_q.size()), 32'd0);

        // Full sweep from 0/0/0 with immediate exhaustion
        sp0 = 5'd0; sp1 = 5'd0; sp2 = 5'd0;
        auto_done = 1'b1;
        load_base = load_entries;
        sweep_q.push_back({15'd0, 16'd0});
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 80000 && sweep_pulses == 0; i++) cyc();
        if (sweep_pulses == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no sweep_done, expected one within 80000 cycles");
        end
        repeat (3) cyc();
        auto_done = 1'b0;
        chk("s_pulses", 32'(sweep_pulses), 32'd1);
        chk("s_loads", 32'(load_entries - load_base), 32'd17576);
        chk("s_busy", 32'(busy), 32'd0);
        chk("s_rotor", 32'({rp2, rp1, rp0}), 32'd0);
        chk("s_hit_count", 32'(hit_count), 32'd0);
        chk("s_overflow_cleared", 32'(overflow), 32'd0);
        chk("s_queue", 32'(sweep_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bombe_sweep_ctrl.md
# bombe_sweep_ctrl

Sequencer that sits directly upstream of the bombe core and drives it across the rotor-position space. For each starting position it:
- holds the core in reset, then waits for a stop (`valid_output`) or exhaustion (`done_compute`);
- logs every stop as a hit record in a small FIFO;
- acknowledges the stop with the two-step `next_attempt_1`/`next_attempt_2` handshake, then advances the three-rotor odometer.

The host (HPS via PIO) starts a sweep, drains hits and monitors progress.

## Interface
Parameters:
- FIFO_DEPTH, 8, hit FIFO entries; power of two, ≥2.
- RST_CYCLES, 2, cycles `bombe_reset` is held per position; ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level; ends sweep early.
- start_pos_0/1/2  in  5 each  starting rotor positions, 0..25; sampled on accepted start.
- bombe_valid  in  1  bombe `valid_output`.
- bombe_done  in  1  bombe `done_compute`.
- bombe_mapping  in  5  bombe `plugboard_passin_mapping_wire`.
- bombe_reset  out  1  reset to bombe.
- next_attempt_1, next_attempt_2, finish_compute  out  1 each  bombe handshake strobes.
- rotor_pos_0/1/2  out  5 each  to bombe `init_rotor_position_*`.
- hit_valid  out  1  FIFO non-empty.
- hit_ready  in  1  pop when `hit_valid`.
- hit_data  out  20  {pos_2, pos_1, pos_0, mapping} of head entry.
- hit_count  out  16  hits accepted this sweep, saturating at 0xFFFF.
- overflow  out  1  sticky; a hit was dropped because the FIFO was full.
- busy  out  1  not IDLE.
- sweep_done  out  1  one-cycle pulse on normal completion.

## Operation
States: IDLE, LOAD, WAIT, HIT, ACK1, ACK2, SKIP, ADVANCE, FIN. All strobes are Moore-decoded from the state register.

- **IDLE**
  - `bombe_reset` = 1.
  - On `start`: latch the three start positions, clear pos_count, hit_count and overflow, then go to LOAD. The FIFO is not cleared.
- **LOAD**
  - `bombe_reset` = 1 for RST_CYCLES cycles, then go to WAIT.
- **WAIT**
  - If `bombe_valid`: go to HIT.
  - Else if `bombe_done`: go to ADVANCE.
  - If both are asserted in the same cycle, `bombe_valid` wins.
- **HIT**
  - If the FIFO is not full: push {rotor_pos_2, rotor_pos_1, rotor_pos_0, bombe_mapping}, increment hit_count, go to ACK1.
  - If the FIFO is full: drop the hit, set overflow, go to SKIP.
- **ACK1**
  - `next_attempt_1` = 1 for one cycle, then go to ACK2.
- **ACK2**
  - `next_attempt_2` = 1 for one cycle, then go to WAIT.
- **SKIP**
  - `finish_compute` = 1 for one cycle (bombe goes VALID→DONE), then go to WAIT. WAIT then sees `bombe_done`.
- **ADVANCE**
  - Odometer step: pos_0+1. On wrap 25→0, carry into pos_1; on its wrap, carry into pos_2. pos_2 wraps 25→0.
  - Increment the 15-bit pos_count.
  - If pos_count reaches 17576: go to FIN. Else go to LOAD.
- **FIN**
  - `sweep_done` = 1 for one cycle, then go to IDLE.
- **abort** in any non-IDLE state: go to IDLE next cycle. No `sweep_done`; FIFO contents are kept.
- **FIFO**
  - Show-ahead; `hit_data` is valid whenever `hit_valid` = 1.
  - Full and empty are judged on the registered count, with no same-cycle bypass. A push when full is never performed, even with a simultaneous pop.
  - Simultaneous push and pop when non-empty and not full: count unchanged.

## Timing
- Reset values:
  - state IDLE, `bombe_reset` = 1.
  - All strobes 0, rotor_pos_* = 0, hit_count = 0, overflow = 0.
  - FIFO empty, `hit_valid` = 0, `busy` = 0.
- `start` at cycle T:
  - LOAD at T+1; `busy` = 1 and rotor_pos = start_pos from T+1.
  - `bombe_reset` deasserts at T+1+RST_CYCLES.
- `bombe_valid` seen in WAIT at cycle N:
  - push at N+1; `hit_valid` = 1 at N+2 if the FIFO was empty.
  - `next_attempt_1` at N+2, `next_attempt_2` at N+3, WAIT at N+4.
- `bombe_done` seen at cycle N: new rotor_pos visible at N+2; LOAD at N+2.
- `start` while busy is ignored.
- Start positions outside 0..25 are treated modulo the odometer: values >25 step to 0 on their first increment.

## Structure
- Package `bombe_pkg`:
  - ALPHABET = 26, POS_W = 5, NUM_POSITIONS = 17576.
  - Hit-record typedef (20 bits, field order as above).
  - Sweep-state enum.
- One sub-module, `hit_fifo` (parameterised depth/width, registered count). The FSM and odometer stay in the top module.

## Test plan
- start_pos 0/0/0, bombe model raises done 3 cycles after each reset release → exactly 17576 LOAD entries, final rotor_pos wraps to 0/0/0, one `sweep_done` pulse, hit_count = 0.
- start_pos 25/25/24, one done → rotor_pos becomes 0/0/25.
- Model gives valid with mapping = 7 at pos 3/0/0 → hit_data = {0,0,3,7}; `next_attempt_1` and `next_attempt_2` each high for exactly one cycle, in consecutive cycles.
- FIFO_DEPTH = 2, `hit_ready` = 0, three hits → third hit dropped, overflow = 1, `finish_compute` pulses once, hit_count = 2.
- valid and done both high in WAIT → HIT path is taken.
- `abort` during ACK1 → IDLE next cycle, `bombe_reset` = 1, no `sweep_done`, FIFO entries intact.
